// File: rtl/gf2_div_pkg.sv
// gf2_div_pkg: shared constants, FSM state codes and leading-one helper for gf2_poly_divider.
package gf2_div_pkg;
    localparam int DEF_N  = 384;
    localparam int MAX_N  = 1024;
    localparam int LAT_R1 = 2 * DEF_N + 2;
    localparam int LAT_R2 = DEF_N + 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    // Index of the highest set bit; 0 for a zero input (callers screen out zero first).
    function automatic int lead_one(input logic [MAX_N-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) idx = v[i] ? i : idx;
        return idx;
    endfunction
endpackage

// File: rtl/gf2_div_step.sv
// gf2_div_step: one combinational GF(2) long-division iteration.
//   r      partial remainder in, deg(r) < dg
//   in_bit next dividend bit shifted in
//   d, dg  divisor and its degree
//   r_out  partial remainder out
//   q      quotient bit produced by this iteration
module gf2_div_step
    import gf2_div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]             r,
    input  logic                     in_bit,
    input  logic [N-1:0]             d,
    input  logic [$clog2(N+1)-1:0]   dg,
    output logic [N-1:0]             r_out,
    output logic                     q
);
    logic [N:0] t;
    assign t     = {r, in_bit};
    assign q     = t[dg];
    // Bit N of t is always zero because deg(r) < dg <= N-1, so it can be dropped.
    assign r_out = t[N-1:0] ^ (q ? d : '0);
endmodule

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: bit-serial carry-less polynomial divider, 2N-bit dividend by N-bit divisor.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (dividend, divisor)
//   out_valid/out_ready result handshake (quotient, remainder, div_zero)
// Build option: define GF2_DIV_RADIX2_EN to retire two quotient bits per cycle.
module gf2_poly_divider
    import gf2_div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
);
    localparam int DW = $clog2(N + 1);
    localparam int KW = $clog2(2 * N);
    logic [1:0]     state;
    // sq holds the unconsumed dividend bits in its top and the quotient bits
    // shifted in at the bottom; after the last iteration it is exactly Q.
    logic [2*N-1:0] sq;
    logic [2*N-1:0] sq_next;
    logic [N-1:0]   d;
    logic [N-1:0]   r;
    logic [N-1:0]   r_next;
    logic [KW-1:0]  k;
    logic [DW-1:0]  dg;
    logic           dz;
    logic           last;
`ifdef GF2_DIV_RADIX2_EN
    localparam logic [KW-1:0] KSTEP = KW'(2);
    logic [N-1:0] r_mid;
    logic         q_hi;
    logic         q_lo;
    gf2_div_step #(.N(N)) u_step_hi (.r(r), .in_bit(sq[2*N-1]), .d(d), .dg(dg), .r_out(r_mid), .q(q_hi));
    gf2_div_step #(.N(N)) u_step_lo (.r(r_mid), .in_bit(sq[2*N-2]), .d(d), .dg(dg), .r_out(r_next), .q(q_lo));
    assign sq_next = {sq[2*N-3:0], q_hi, q_lo};
    assign last    = k == KW'(1);
`else
    localparam logic [KW-1:0] KSTEP = KW'(1);
    logic qb;
    gf2_div_step #(.N(N)) u_step (.r(r), .in_bit(sq[2*N-1]), .d(d), .dg(dg), .r_out(r_next), .q(qb));
    assign sq_next = {sq[2*N-2:0], qb};
    assign last    = k == '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sq    <= '0;
            d     <= '0;
            r     <= '0;
            k     <= '0;
            dg    <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sq    <= dividend;
                    d     <= divisor;
                    r     <= '0;
                    k     <= KW'(2 * N - 1);
                    dz    <= 1'b0;
                    state <= NORM;
                end
                NORM: if (d == '0) begin
                    dz    <= 1'b1;
                    sq    <= '0;
                    state <= DONE;
                end else begin
                    dg    <= DW'(lead_one(MAX_N'(d)));
                    state <= DIV;
                end
                DIV: begin
                    sq    <= sq_next;
                    r     <= r_next;
                    k     <= k - KSTEP;
                    state <= last ? DONE : DIV;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    // Results are masked outside DONE so partial work is never visible.
    assign quotient  = out_valid ? sq : '0;
    assign remainder = out_valid ? r : '0;
    assign div_zero  = out_valid & dz;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb_gf2_poly_divider: randomized self-checking bench for gf2_poly_divider against a polynomial-arithmetic model.
module tb_gf2_poly_divider;
    localparam int N = 32;
    localparam int W = 2 * N;
`ifdef GF2_DIV_RADIX2_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = 2 * N + 2;
`endif
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;
    int checks = 0;
    int errors = 0;

    gf2_poly_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) if (b[i]) p ^= W'(a) << i;
        return p;
    endfunction

    function automatic int degree(input logic [N-1:0] v);
        int dv;
        dv = -1;
        for (int i = 0; i < N; i++) if (v[i]) dv = i;
        return dv;
    endfunction

    // Schoolbook polynomial long division over GF(2).
    task automatic ref_div(input logic [W-1:0] x, input logic [N-1:0] y,
                           output logic [W-1:0] q, output logic [N-1:0] rm);
        logic [W-1:0] rem;
        int dy;
        dy = degree(y);
        q = '0;
        rem = x;
        if (dy < 0) rem = '0;
        else for (int i = W - 1; i >= dy; i--) if (rem[i]) begin
            rem ^= W'(y) << (i - dy);
            q[i - dy] = 1'b1;
        end
        rm = rem[N-1:0];
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] dvd, input logic [N-1:0] dvs,
                          input logic [W-1:0] eq, input logic [N-1:0] er, input logic edz, input int elat);
        int cnt;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            in_valid = 1'b0;
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
        end while (!out_valid && cnt < 4 * W);
        chk({tag, ".lat"}, W'(cnt), W'(elat));
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, W'(remainder), W'(er));
        chk({tag, ".dz"}, W'(div_zero), W'(edz));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] a, b, rr, mask, er;
        logic [W-1:0] x, eq;
        int cnt;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.in_ready", W'(in_ready), W'(1));
        chk("rst.out_valid", W'(out_valid), W'(0));
        chk("rst.q", quotient, '0);
        chk("rst.r", W'(remainder), '0);
        chk("rst.dz", W'(div_zero), '0);

        run_op("small", W'(64'h15), N'(32'h3), W'(64'hC), N'(32'h1), 1'b0, LAT);
        run_op("unit", '1, N'(1), '1, '0, 1'b0, LAT);
        x = {$urandom, $urandom};
        run_op("divzero", x, '0, '0, '0, 1'b1, 2);
        b = $urandom | 1;
        run_op("dvd_zero", '0, b, '0, '0, 1'b0, LAT);

        for (int i = 0; i < 200; i++) begin
            a = $urandom; if (a == '0) a = 1;
            b = $urandom >> $urandom_range(0, N - 1); if (b == '0) b = 1;
            run_op("roundtrip", clmul(a, b), b, W'(a), '0, 1'b0, LAT);
        end
        for (int i = 0; i < 60; i++) begin
            a = $urandom; if (a == '0) a = 1;
            b = $urandom >> $urandom_range(0, N - 1); if (b == '0) b = 1;
            mask = (N'(1) << degree(b)) - N'(1);
            rr = $urandom & mask;
            run_op("remcase", clmul(a, b) ^ W'(rr), b, W'(a), rr, 1'b0, LAT);
        end
        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom};
            b = $urandom >> $urandom_range(0, N - 1); if (b == '0) b = 3;
            ref_div(x, b, eq, er);
            run_op("random", x, b, eq, er, 1'b0, LAT);
        end

        // Backpressure with stray in_valid pulses during the division.
        x = {$urandom, $urandom};
        b = $urandom | 32'h100;
        ref_div(x, b, eq, er);
        out_ready = 1'b0;
        in_valid = 1'b1;
        dividend = x;
        divisor = b;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            in_valid = (cnt % 5 == 0);
            dividend = {$urandom, $urandom};
            divisor = $urandom;
        end while (!out_valid && cnt < 4 * W);
        in_valid = 1'b0;
        chk("bp.lat", W'(cnt), W'(LAT));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp.q", quotient, eq);
            chk("bp.r", W'(remainder), W'(er));
            chk("bp.out_valid", W'(out_valid), W'(1));
            chk("bp.in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.in_ready_after", W'(in_ready), W'(1));
        chk("bp.out_valid_after", W'(out_valid), W'(0));

        // Reset in the middle of DIV.
        in_valid = 1'b1;
        dividend = {$urandom, $urandom};
        divisor = $urandom | 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (1 + 20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.out_valid", W'(out_valid), W'(0));
        chk("midrst.q", quotient, '0);
        chk("midrst.in_ready", W'(in_ready), W'(1));
        x = {$urandom, $urandom};
        b = $urandom | 32'h8000_0000;
        ref_div(x, b, eq, er);
        run_op("after_rst", x, b, eq, er, 1'b0, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
